// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: shared state encoding and sizing constants for the memory stream reader
package mem_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int MEM_RD_LAT = 1;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/mem_stream_skid.sv
// mem_stream_skid: 2-entry in-order output buffer; head entry drives the stream, occupancy exposed for credit control
module mem_stream_skid
    import mem_stream_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] tail;
    logic [1:0]   wpos;

    assign wpos = occ - {1'b0, pop};

    // shift the tail forward on pop, then write the new word into the first free slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (pop && occ == 2'(SKID_DEPTH)) dout <= tail;
            if (push && wpos == 2'd0) dout <= din;
            if (push && wpos == 2'd1) tail <= din;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: walks an address window of a 1-cycle-latency memory and streams the words out (optional MEM_STREAM_POS_EN adds m_pos/pass_cnt)
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
`ifdef MEM_STREAM_POS_EN
    ,
    output logic [ADDR_W-1:0] m_pos,
    output logic [15:0]       pass_cnt
`endif
);
`ifdef MEM_STREAM_POS_EN
    localparam int PW = DATA_W + 1 + ADDR_W;
`else
    localparam int PW = DATA_W + 1;
`endif

    state_t            state;
    logic [ADDR_W-1:0] cur, base_q, last_q;
    logic              loop_q, rd_vld, rd_last;
    logic              pop, issue, is_last, drained;
    logic [1:0]        occ;
    logic [2:0]        pend;
    logic [PW-1:0]     din, dout;

    // a new read is allowed only if every outstanding word is guaranteed a buffer slot
    assign m_valid  = occ != 2'd0;
    assign pop      = m_valid && m_ready;
    assign pend     = {1'b0, occ} + {2'b0, rd_vld} - {2'b0, pop};
    assign issue    = state == RUN && !stop && pend < 3'(SKID_DEPTH);
    assign is_last  = cur == last_q;
    assign drained  = !rd_vld && (occ == 2'd0 || (occ == 2'd1 && pop));
    assign mem_en   = issue;
    assign mem_addr = cur;
    assign m_data   = dout[DATA_W-1:0];
    assign m_last   = dout[DATA_W];

`ifdef MEM_STREAM_POS_EN
    logic [ADDR_W-1:0] pos_cnt, rd_pos;

    assign din   = {rd_pos, rd_last, mem_dout};
    assign m_pos = dout[PW-1:DATA_W+1];

    // word index within the pass and saturating count of completed passes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_cnt  <= '0;
            pass_cnt <= '0;
        end else begin
            if (issue) pos_cnt <= is_last ? '0 : pos_cnt + ADDR_W'(1);
            if (pop && m_last && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            if (state == IDLE && start) begin
                pos_cnt  <= '0;
                pass_cnt <= '0;
            end
        end
    end
`else
    assign din = {rd_last, mem_dout};
`endif

    // tag the read in flight so its data and last flag land in the buffer together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_last <= issue && is_last;
`ifdef MEM_STREAM_POS_EN
            rd_pos  <= pos_cnt;
`endif
        end
    end

    // control FSM: latch window, step the address, drain outstanding words, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= '0;
            base_q <= '0;
            last_q <= '0;
            loop_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    last_q <= last_addr;
                    loop_q <= loop_en;
                    cur    <= base_addr;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: if (stop) state <= DRAIN;
                else if (issue) begin
                    cur <= (is_last && loop_q) ? base_q : cur + ADDR_W'(1);
                    if (is_last && !loop_q) state <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_stream_skid #(.W(PW)) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_vld),
        .pop  (pop),
        .din  (din),
        .dout (dout),
        .occ  (occ)
    );
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed bench for mem_stream_reader with a behavioural 1-cycle-latency memory
module tb_mem_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [10:0] base_addr = '0;
    logic [10:0] last_addr = '0;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [15:0] mem_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int iss_n = 0;
    int done_n = 0;
    int done_cyc = 0;
    logic [15:0] dq[$];
    logic        lq[$];
    int          cq[$];
    logic [15:0] cap;

    mem_stream_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .base_addr(base_addr),
        .last_addr(last_addr),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory word at address a is 0xA800 | a
    always @(posedge clk) if (mem_en) mem_dout <= {5'h15, mem_addr};

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            dq.push_back(m_data);
            lq.push_back(m_last);
            cq.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (mem_en) iss_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [10:0] b, input logic [10:0] l, input bit lp, input bit stp);
        dq.delete();
        lq.delete();
        cq.delete();
        iss_n = 0;
        done_n = 0;
        base_addr = b;
        last_addr = l;
        loop_en = lp;
        start = 1'b1;
        stop = stp;
        step();
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        step();
    endtask

    task automatic check_seq(input string tag, input int b, input int len, input int n);
        if (n >= 0) check({tag, "_cnt"}, dq.size(), n);
        check({tag, "_iss"}, dq.size(), iss_n);
        foreach (dq[i]) begin
            check($sformatf("%s_d%0d", tag, i), 32'(dq[i]), 32'hA800 | ((b + i % len) & 32'h7FF));
            check($sformatf("%s_l%0d", tag, i), 32'(lq[i]), 32'((i % len) == len - 1));
        end
    endtask

    initial begin
        step();
        step();
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        step();

        go(11'h005, 11'h008, 1'b0, 1'b0);
        check("t1_busy", 32'(busy), 1);
        check("t1_mem_en", 32'(mem_en), 1);
        check("t1_addr0", 32'(mem_addr), 32'h5);
        check("t1_valid_c1", 32'(m_valid), 0);
        step();
        check("t1_valid_c2", 32'(m_valid), 0);
        step();
        check("t1_valid_c3", 32'(m_valid), 1);
        check("t1_first", 32'(m_data), 32'hA805);
        wait_done("t1", 100);
        step();
        check_seq("t1", 5, 4, 4);
        check("t1_consec", 32'(cq[cq.size() - 1] - cq[0]), 3);
        check("t1_done_lat", 32'(done_cyc), 32'(cq[cq.size() - 1] + 1));
        check("t1_done_once", 32'(done_n), 1);
        check("t1_busy_off", 32'(busy), 0);

        go(11'h010, 11'h010, 1'b0, 1'b1);
        wait_done("t2", 100);
        check_seq("t2", 16, 1, 1);

        go(11'h7FE, 11'h001, 1'b0, 1'b0);
        wait_done("t3", 100);
        check_seq("t3", 32'h7FE, 4, 4);

        go(11'h002, 11'h004, 1'b1, 1'b0);
        repeat (30) begin
            m_ready = ~m_ready;
            step();
        end
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        m_ready = 1'b1;
        wait_done("t4", 100);
        check_seq("t4", 2, 3, -1);
        check("t4_enough", 32'(dq.size() >= 9), 1);
        check("t4_busy_off", 32'(busy), 0);
        check("t4_idle_en", 32'(mem_en), 0);

        go(11'h020, 11'h02F, 1'b0, 1'b0);
        repeat (4) step();
        m_ready = 1'b0;
        step();
        cap = m_data;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("t5_en%0d", i), 32'(mem_en), 0);
            check($sformatf("t5_vld%0d", i), 32'(m_valid), 1);
            check($sformatf("t5_hold%0d", i), 32'(m_data), 32'(cap));
        end
        check("t5_buffered", 32'(iss_n - dq.size() <= 2), 1);
        m_ready = 1'b1;
        wait_done("t5", 100);
        check_seq("t5", 32'h20, 16, 16);

        go(11'h040, 11'h04F, 1'b0, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("t6_mem_en", 32'(mem_en), 0);
        check("t6_mem_addr", 32'(mem_addr), 0);
        check("t6_m_valid", 32'(m_valid), 0);
        check("t6_m_data", 32'(m_data), 0);
        check("t6_m_last", 32'(m_last), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        rst_n = 1'b1;
        dq.delete();
        repeat (4) step();
        check("t6_no_stale", dq.size(), 0);
        go(11'h050, 11'h052, 1'b0, 1'b0);
        wait_done("t6", 100);
        check_seq("t6", 32'h50, 3, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
